spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 165 ++++++++++++++++
 tb/tb_spi_slave.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI slave with pro_clk-domain synchronizers, one-byte tx buffer and rx holding register.
// Mode is fixed per instance by CPOL/CPHA; all sclk/ss_n/mosi activity is sampled on pro_clk.
module spi_slave #(
   parameter bit CPOL = 1'b0,
   parameter bit CPHA = 1'b0
) (
   input  logic       pro_clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       ss_n,
   input  logic       mosi,
   output logic       miso,
   input  logic [7:0] tx_data,
   input  logic       tx_load,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   output logic       overrun,
   input  logic       overrun_clr,
   output logic       busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0] r_state;
   logic [2:0] r_sclk_sync;
   logic [2:0] r_ss_sync;
   logic [1:0] r_mosi_sync;
   logic       r_s1_valid;
   logic       r_armed;
   logic [7:0] r_sr;
   logic [3:0] r_bit_cnt;
   logic [7:0] r_txbuf;
   logic       r_tx_ready;
   logic [7:0] r_rx_data;
   logic       r_rx_valid;
   logic       r_overrun;
   logic       r_miso;

   logic w_lead;
   logic w_trail;
   logic w_sample;
   logic w_shift;
   logic w_ss_fall;
   logic w_ss_rise;
   logic w_load_go;
   logic w_done;

   assign w_lead    = (r_sclk_sync[1] != CPOL) && (r_sclk_sync[2] == CPOL);
   assign w_trail   = (r_sclk_sync[1] == CPOL) && (r_sclk_sync[2] != CPOL);
   assign w_sample  = CPHA ? w_trail : w_lead;
   assign w_shift   = CPHA ? w_lead : w_trail;
   // A falling ss_n only counts once ss_n has really been seen high since reset.
   assign w_ss_fall = !r_ss_sync[1] && r_ss_sync[2] && r_armed;
   assign w_ss_rise = r_ss_sync[1] && !r_ss_sync[2];
   assign w_load_go = (r_state == LOAD) && !w_ss_rise;
   assign w_done    = (r_state == DONE);

   always_ff @(posedge pro_clk) begin
      if (rst) begin
         r_sclk_sync <= {3{CPOL}};
         r_ss_sync   <= 3'b111;
         r_mosi_sync <= '0;
         r_s1_valid  <= 1'b0;
         r_armed     <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[1:0], sclk};
         r_ss_sync   <= {r_ss_sync[1:0], ss_n};
         r_mosi_sync <= {r_mosi_sync[0], mosi};
         r_s1_valid  <= 1'b1;
         if (r_s1_valid && r_ss_sync[0])
            r_armed <= 1'b1;
      end
   end

   always_ff @(posedge pro_clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_sr      <= '0;
         r_bit_cnt <= '0;
         r_miso    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_miso <= 1'b0;
               if (w_ss_fall)
                  r_state <= LOAD;
            end
            LOAD: begin
               r_bit_cnt <= '0;
               if (w_ss_rise) begin
                  r_state <= IDLE;
               end else begin
                  r_sr <= r_tx_ready ? 8'h00 : r_txbuf;
                  if (!CPHA)
                     r_miso <= r_tx_ready ? 1'b0 : r_txbuf[7];
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               if (w_ss_rise) begin
                  r_bit_cnt <= '0;
                  r_state   <= IDLE;
               end else begin
                  if (w_sample) begin
                     r_sr      <= {r_sr[6:0], r_mosi_sync[1]};
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                     if (r_bit_cnt == 4'd7)
                        r_state <= DONE;
                  end
                  if (w_shift)
                     r_miso <= r_sr[7];
               end
            end
            default: begin
               r_state <= r_ss_sync[1] ? IDLE : LOAD;
            end
         endcase
      end
   end

   // A tx_load coinciding with LOAD wins: the old byte is shifted, the new one waits.
   always_ff @(posedge pro_clk) begin
      if (rst) begin
         r_txbuf    <= '0;
         r_tx_ready <= 1'b1;
      end else if (tx_load) begin
         r_txbuf    <= tx_data;
         r_tx_ready <= 1'b0;
      end else if (w_load_go) begin
         r_tx_ready <= 1'b1;
      end
   end

   always_ff @(posedge pro_clk) begin
      if (rst) begin
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         if (w_done) begin
            r_rx_data  <= r_sr;
            r_rx_valid <= 1'b1;
         end else if (rx_ack) begin
            r_rx_valid <= 1'b0;
         end
         if (w_done && r_rx_valid && !rx_ack)
            r_overrun <= 1'b1;
         else if (overrun_clr)
            r_overrun <= 1'b0;
      end
   end

   assign miso     = (r_state == IDLE) ? 1'b0 : r_miso;
   assign tx_ready = r_tx_ready;
   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;
   assign overrun  = r_overrun;
   assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: a mode-0 and a mode-3 instance share one bench-side SPI master.
// Received bytes are queued at issue time and popped by a monitor on each rx_valid rise.
module tb_spi_slave;

   localparam int HALF = 80;

   logic pro_clk = 1'b0;
   logic rst     = 1'b1;
   logic sel     = 1'b0;
   logic m_sclk  = 1'b0;
   logic m_ss    = 1'b1;
   logic m_mosi  = 1'b0;
   logic [7:0] tx_data = '0;
   logic tx_load  = 1'b0;
   logic ack_stim = 1'b0;
   logic ack_mon  = 1'b0;
   logic ovr_clr  = 1'b0;
   bit   cpol = 1'b0;
   bit   cpha = 1'b0;
   bit   auto_ack = 1'b1;
   logic prev_valid = 1'b0;

   int vectors = 0;
   int errors  = 0;
   logic [7:0] exp_q[$];
   logic       m_full = 1'b0;
   logic [7:0] m_val  = '0;

   logic sclk0, ss0, sclk3, ss3, txl0, txl3, ack0, ack3, clr0, clr3;
   logic miso0, miso3, txr0, txr3, rxv0, rxv3, ovr0, ovr3, busy0, busy3;
   logic [7:0] rxd0, rxd3;
   logic miso_w, txr_w, rxv_w, ovr_w, busy_w;
   logic [7:0] rxd_w;

   assign sclk0 = sel ? 1'b0 : m_sclk;
   assign ss0   = sel ? 1'b1 : m_ss;
   assign sclk3 = sel ? m_sclk : 1'b1;
   assign ss3   = sel ? m_ss : 1'b1;
   assign txl0  = tx_load & ~sel;
   assign txl3  = tx_load & sel;
   assign ack0  = (ack_stim | ack_mon) & ~sel;
   assign ack3  = (ack_stim | ack_mon) & sel;
   assign clr0  = ovr_clr & ~sel;
   assign clr3  = ovr_clr & sel;

   assign miso_w = sel ? miso3 : miso0;
   assign txr_w  = sel ? txr3 : txr0;
   assign rxv_w  = sel ? rxv3 : rxv0;
   assign ovr_w  = sel ? ovr3 : ovr0;
   assign busy_w = sel ? busy3 : busy0;
   assign rxd_w  = sel ? rxd3 : rxd0;

   spi_slave #(.CPOL(1'b0), .CPHA(1'b0)) u_dut0 (
      .pro_clk(pro_clk), .rst(rst), .sclk(sclk0), .ss_n(ss0), .mosi(m_mosi), .miso(miso0),
      .tx_data(tx_data), .tx_load(txl0), .tx_ready(txr0), .rx_data(rxd0), .rx_valid(rxv0),
      .rx_ack(ack0), .overrun(ovr0), .overrun_clr(clr0), .busy(busy0));

   spi_slave #(.CPOL(1'b1), .CPHA(1'b1)) u_dut3 (
      .pro_clk(pro_clk), .rst(rst), .sclk(sclk3), .ss_n(ss3), .mosi(m_mosi), .miso(miso3),
      .tx_data(tx_data), .tx_load(txl3), .tx_ready(txr3), .rx_data(rxd3), .rx_valid(rxv3),
      .rx_ack(ack3), .overrun(ovr3), .overrun_clr(clr3), .busy(busy3));

   initial forever #5 pro_clk = ~pro_clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: got no end of test, expected finish before 2ms");
      $fatal(1);
   end

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // kind 1 = rx_ack, kind 2 = overrun_clr, timed to land on the DONE cycle
   task automatic fire_strobe(input int kind);
      fork
         begin
            #30;
            if (kind == 1) ack_stim = 1'b1;
            else ovr_clr = 1'b1;
            #10;
            ack_stim = 1'b0;
            ovr_clr  = 1'b0;
         end
      join_none
   endtask

   task automatic spi_bit(input logic mo, input bit strobe, input int kind, output logic mi);
      if (!cpha) begin
         m_mosi = mo;
         #HALF;
         m_sclk = ~cpol;
         mi = miso_w;
         if (strobe) fire_strobe(kind);
         #HALF;
         m_sclk = cpol;
      end else begin
         m_sclk = ~cpol;
         m_mosi = mo;
         #HALF;
         m_sclk = cpol;
         mi = miso_w;
         if (strobe) fire_strobe(kind);
         #HALF;
      end
   endtask

   task automatic spi_byte(input logic [7:0] mo, input int kind, output logic [7:0] mi);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(mo[i], (i == 0) && (kind != 0), kind, b);
         mi[i] = b;
      end
   endtask

   task automatic load_tx(input logic [7:0] v);
      tx_data = v;
      tx_load = 1'b1;
      #10;
      tx_load = 1'b0;
      m_val  = v;
      m_full = 1'b1;
   endtask

   task automatic pulse_ack();
      ack_stim = 1'b1;
      #10;
      ack_stim = 1'b0;
   endtask

   task automatic set_mode(input bit m);
      m_ss   = 1'b1;
      cpol   = m;
      cpha   = m;
      m_sclk = m;
      sel    = m;
      #100;
   endtask

   task automatic frame(input int n, input logic [7:0] d0, input logic [7:0] d1,
                        input bit push0, input bit push1, input int kind,
                        input bit ld, input logic [7:0] ldv);
      logic [7:0] mi, e0, e1;
      m_ss = 1'b0;
      if (ld) begin
         fork
            begin
               #30;
               tx_data = ldv;
               tx_load = 1'b1;
               #10;
               tx_load = 1'b0;
            end
         join_none
      end
      e0 = m_full ? m_val : 8'h00;
      m_full = 1'b0;
      if (ld) begin
         m_val  = ldv;
         m_full = 1'b1;
      end
      #100;
      if (push0) exp_q.push_back(d0);
      spi_byte(d0, (n == 1) ? kind : 0, mi);
      check8("miso_byte0", mi, e0);
      if (n == 2) begin
         e1 = m_full ? m_val : 8'h00;
         m_full = 1'b0;
         if (push1) exp_q.push_back(d1);
         spi_byte(d1, kind, mi);
         check8("miso_byte1", mi, e1);
      end
      #HALF;
      m_ss = 1'b1;
      m_full = 1'b0;   // ss_n still low at DONE re-enters LOAD, which drains the buffer
      #200;
      check1("tx_ready_after_frame", txr_w, 1'b1);
   endtask

   initial begin
      forever begin
         @(negedge pro_clk);
         ack_mon = 1'b0;
         if (rxv_w === 1'b1 && prev_valid !== 1'b1) begin
            if (exp_q.size() == 0) begin
               vectors++;
               errors++;
               $display("FAIL rx_unexpected: got rx_data %h, expected no byte", rxd_w);
            end else begin
               check8("rx_data", rxd_w, exp_q.pop_front());
               if (auto_ack) begin
                  check1("overrun_clean", ovr_w, 1'b0);
                  ack_mon = 1'b1;
               end
            end
         end
         prev_valid = rxv_w;
      end
   end

   initial begin
      logic b;
      logic [7:0] d;
      int nl;

      repeat (4) @(negedge pro_clk);
      rst = 1'b0;
      check1("rst_miso", miso_w, 1'b0);
      check8("rst_rx_data", rxd_w, 8'h00);
      check1("rst_rx_valid", rxv_w, 1'b0);
      check1("rst_overrun", ovr_w, 1'b0);
      check1("rst_busy", busy_w, 1'b0);
      check1("rst_tx_ready", txr_w, 1'b1);

      load_tx(8'hA5);
      check1("tx_ready_loaded", txr_w, 1'b0);
      frame(1, 8'h3C, 8'h00, 1, 0, 0, 0, 8'h00);

      set_mode(1'b1);
      frame(1, 8'hFF, 8'h00, 1, 0, 0, 0, 8'h00);

      set_mode(1'b0);
      load_tx(8'h6B);
      frame(2, 8'h5A, 8'hC3, 1, 1, 0, 1, 8'hC3);

      auto_ack = 1'b0;
      frame(2, 8'h9C, 8'hE7, 1, 0, 1, 0, 8'h00);
      check8("ackdone_rx_data", rxd_w, 8'hE7);
      check1("ackdone_rx_valid", rxv_w, 1'b1);
      check1("ackdone_overrun", ovr_w, 1'b0);
      pulse_ack();
      check1("ack_clears_valid", rxv_w, 1'b0);

      frame(2, 8'h12, 8'h34, 1, 0, 2, 0, 8'h00);
      check8("overrun_rx_data", rxd_w, 8'h34);
      check1("overrun_rx_valid", rxv_w, 1'b1);
      check1("overrun_set_wins", ovr_w, 1'b1);
      ovr_clr = 1'b1;
      #10;
      ovr_clr = 1'b0;
      check1("overrun_cleared", ovr_w, 1'b0);

      m_ss = 1'b0;
      m_full = 1'b0;
      #100;
      for (int i = 0; i < 4; i++) spi_bit(1'b1, 0, 0, b);
      load_tx(8'h77);
      rst = 1'b1;
      #10;
      rst = 1'b0;
      m_full = 1'b0;
      check1("midrst_miso", miso_w, 1'b0);
      check8("midrst_rx_data", rxd_w, 8'h00);
      check1("midrst_rx_valid", rxv_w, 1'b0);
      check1("midrst_overrun", ovr_w, 1'b0);
      check1("midrst_busy", busy_w, 1'b0);
      check1("midrst_tx_ready", txr_w, 1'b1);
      for (int i = 0; i < 4; i++) spi_bit(1'b0, 0, 0, b);
      check1("no_start_on_held_ss", busy_w, 1'b0);
      m_ss = 1'b1;
      #200;
      auto_ack = 1'b1;
      frame(1, 8'h55, 8'h00, 1, 0, 0, 0, 8'h00);

      m_ss = 1'b0;
      m_full = 1'b0;
      #100;
      for (int i = 0; i < 5; i++) spi_bit(1'($urandom_range(0, 1)), 0, 0, b);
      m_ss = 1'b1;
      #40;
      check1("abort_busy", busy_w, 1'b0);
      check1("abort_rx_valid", rxv_w, 1'b0);
      #200;
      frame(1, 8'h81, 8'h00, 1, 0, 0, 0, 8'h00);

      for (int k = 0; k < 24; k++) begin
         set_mode(1'($urandom_range(0, 1)));
         nl = int'($urandom_range(0, 2));
         for (int j = 0; j < nl; j++) load_tx(8'($urandom()));
         d = 8'($urandom());
         frame(1, d, 8'h00, 1, 0, 0, 0, 8'h00);
      end

      #500;
      check8("scoreboard_drained", 8'(exp_q.size()), 8'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
